// File: rtl/program_sequencer_pkg.sv
// ============================================================================
//  program_sequencer_pkg
//  Shared widths, default watchdog limit and FSM state encoding.
//  Rev 1.0
// ============================================================================
`default_nettype none

package program_sequencer_pkg;
  localparam int ADDR_W = 8;
  localparam int CNT_W  = 16;
  localparam int PTR_W  = 4;   // must be able to hold NUM_PROGS (max 8)
  localparam int IDX_W  = 3;

  localparam logic [CNT_W-1:0] DEFAULT_TIMEOUT = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SELECT = 3'd1,
    LAUNCH = 3'd2,
    RUN    = 3'd3,
    RECORD = 3'd4,
    FINISH = 3'd5
  } seq_state_t;
endpackage

`default_nettype wire

// File: rtl/prog_slot_picker.sv
// ============================================================================
//  prog_slot_picker
//  Finds the lowest-index set mask bit at or above the slot pointer.
//  Rev 1.0
// ============================================================================
`default_nettype none

module prog_slot_picker
  import program_sequencer_pkg::*;
#(
  parameter int NUM_PROGS = 3
) (
  input  logic [NUM_PROGS-1:0] mask,
  input  logic [PTR_W-1:0]     ptr,
  output logic                 found,
  output logic [IDX_W-1:0]     idx
);

  // Scanning downward lets the lowest qualifying slot overwrite the others.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = NUM_PROGS - 1; i >= 0; i--) begin
      if (mask[i] && (PTR_W'(i) >= ptr)) begin
        found = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/program_sequencer.sv
// ============================================================================
//  program_sequencer
//  Launches enabled program slots on the 8-bit core and times each run.
//  Optional per-slot cycle log enabled by SEQ_PERF_LOG_EN.
//  Rev 1.0
// ============================================================================
`default_nettype none

module program_sequencer
  import program_sequencer_pkg::*;
#(
  parameter int              NUM_PROGS      = 3,
  parameter int              START_CYCLES   = 2,
  parameter logic [CNT_W-1:0] TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic                        CLK,
  input  logic                        Reset,
  input  logic                        RunReq,
  input  logic [NUM_PROGS-1:0]        ProgMask,
  input  logic [ADDR_W*NUM_PROGS-1:0] ProgAddrs,
  input  logic                        CoreDone,
  output logic                        CoreStart,
  output logic [ADDR_W-1:0]           CoreStartAddr,
  output logic                        Busy,
  output logic                        RunAck,
  output logic [IDX_W-1:0]            CurProg,
  output logic [CNT_W-1:0]            CycleCount,
  output logic                        CountValid,
`ifdef SEQ_PERF_LOG_EN
  input  logic [IDX_W-1:0]            LogIdx,
  output logic [CNT_W-1:0]            LogData,
`endif
  output logic                        TimedOut
);

  localparam int LAUNCH_W = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;

  seq_state_t           state, next_state;
  logic [NUM_PROGS-1:0] mask_q;
  logic [PTR_W-1:0]     ptr;
  logic [LAUNCH_W-1:0]  launch_cnt;
  logic [CNT_W-1:0]     run_cnt;
  logic [CNT_W:0]       run_inc;
  logic                 pick_found;
  logic [IDX_W-1:0]     pick_idx;
  logic [IDX_W-1:0]     addr_sel;
  logic [ADDR_W-1:0]    addr_live;
  logic                 accept, launch_last, done_ok, timeout_hit;

  prog_slot_picker #(.NUM_PROGS(NUM_PROGS)) u_picker (
    .mask  (mask_q),
    .ptr   (ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign accept      = (state == IDLE) && RunReq && !Busy;
  assign launch_last = (launch_cnt == LAUNCH_W'(START_CYCLES - 1));
  assign run_inc     = {1'b0, run_cnt} + (CNT_W + 1)'(1);
  // First RUN cycle (run_cnt == 0) may still see the previous program's done.
  assign done_ok     = CoreDone && (run_cnt != '0);
  assign timeout_hit = (run_inc >= {1'b0, TIMEOUT_CYCLES});
  assign CoreStart   = (state == LAUNCH);

  assign addr_sel = (state == SELECT) ? pick_idx : CurProg;
  always_comb begin
    addr_live = '0;
    for (int i = 0; i < NUM_PROGS; i++) begin
      if (addr_sel == IDX_W'(i)) addr_live = ProgAddrs[i*ADDR_W +: ADDR_W];
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = SELECT;
      SELECT:  next_state = pick_found ? LAUNCH : FINISH;
      LAUNCH:  if (launch_last) next_state = RUN;
      RUN:     if (done_ok || timeout_hit) next_state = RECORD;
      RECORD:  next_state = SELECT;
      FINISH:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state         <= IDLE;
      mask_q        <= '0;
      ptr           <= '0;
      launch_cnt    <= '0;
      run_cnt       <= '0;
      CoreStartAddr <= '0;
      Busy          <= 1'b0;
      RunAck        <= 1'b0;
      CurProg       <= '0;
      CycleCount    <= '0;
      CountValid    <= 1'b0;
      TimedOut      <= 1'b0;
    end else begin
      state      <= next_state;
      RunAck     <= 1'b0;
      CountValid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            mask_q   <= ProgMask;
            ptr      <= '0;
            TimedOut <= 1'b0;
            Busy     <= 1'b1;
          end else begin
            Busy <= 1'b0;
          end
        end
        SELECT: begin
          launch_cnt <= '0;
          if (pick_found) begin
            CurProg       <= pick_idx;
            CoreStartAddr <= addr_live;
          end
        end
        LAUNCH: begin
          CoreStartAddr <= addr_live;
          launch_cnt    <= launch_cnt + LAUNCH_W'(1);
          run_cnt       <= '0;
        end
        RUN: begin
          run_cnt <= (&run_cnt) ? run_cnt : run_inc[CNT_W-1:0];
          if (!done_ok && timeout_hit) TimedOut <= 1'b1;
        end
        RECORD: begin
          CycleCount <= run_cnt;
          CountValid <= 1'b1;
          ptr        <= PTR_W'(CurProg) + PTR_W'(1);
          for (int i = 0; i < NUM_PROGS; i++) begin
            if (CurProg == IDX_W'(i)) mask_q[i] <= 1'b0;
          end
        end
        FINISH:  RunAck <= 1'b1;
        default: ;
      endcase
    end
  end

`ifdef SEQ_PERF_LOG_EN
  logic [CNT_W-1:0] perf_log [NUM_PROGS];

  always_ff @(posedge CLK) begin
    if (Reset || accept) begin
      for (int i = 0; i < NUM_PROGS; i++) perf_log[i] <= '0;
    end else if (state == RECORD) begin
      for (int i = 0; i < NUM_PROGS; i++) begin
        if (CurProg == IDX_W'(i)) perf_log[i] <= run_cnt;
      end
    end
  end

  always_comb begin
    LogData = '0;
    for (int i = 0; i < NUM_PROGS; i++) begin
      if (LogIdx == IDX_W'(i)) LogData = perf_log[i];
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_program_sequencer.sv
// ============================================================================
//  tb_program_sequencer
//  Scoreboard bench: a core model answers launches; expected launches and
//  cycle counts are queued per scenario and matched as the sequencer reports.
//  Rev 1.0
// ============================================================================
`default_nettype none

module tb_program_sequencer;
  localparam int NP = 3;

  logic            CLK = 1'b0;
  logic            Reset, RunReq, CoreDone;
  logic [NP-1:0]   ProgMask;
  logic [8*NP-1:0] ProgAddrs;
  logic            CoreStart, Busy, RunAck, CountValid, TimedOut;
  logic [7:0]      CoreStartAddr;
  logic [2:0]      CurProg;
  logic [15:0]     CycleCount;
`ifdef SEQ_PERF_LOG_EN
  logic [2:0]      LogIdx;
  logic [15:0]     LogData;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct packed { logic [2:0] slot; logic [7:0]  addr; } launch_t;
  typedef struct packed { logic [2:0] slot; logic [15:0] cnt;  } count_t;
  launch_t exp_launch[$];
  count_t  exp_count[$];
  launch_t le;
  count_t  ce;

  int   ack_count = 0, launch_count = 0, cv_count = 0, start_len = 0;
  logic prev_start = 1'b0;

  // Core model: 0 = done N cycles after Start falls, 1 = done stuck high, 2 = never done
  int core_mode = 0, done_delay = 10, core_k = 0;

  program_sequencer #(.NUM_PROGS(NP), .START_CYCLES(2), .TIMEOUT_CYCLES(16'd20)) dut (
    .CLK(CLK), .Reset(Reset), .RunReq(RunReq), .ProgMask(ProgMask), .ProgAddrs(ProgAddrs),
    .CoreDone(CoreDone), .CoreStart(CoreStart), .CoreStartAddr(CoreStartAddr), .Busy(Busy),
    .RunAck(RunAck), .CurProg(CurProg), .CycleCount(CycleCount), .CountValid(CountValid),
`ifdef SEQ_PERF_LOG_EN
    .LogIdx(LogIdx), .LogData(LogData),
`endif
    .TimedOut(TimedOut)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (CoreStart) core_k <= 0;
    else if (core_k < 100000) core_k <= core_k + 1;
  end
  assign CoreDone = (core_mode == 1) || (core_mode == 0 && !CoreStart && core_k >= done_delay - 1);

  // Scoreboard monitor
  always @(negedge CLK) begin
    if (CoreStart === 1'b1 && !prev_start) begin
      launch_count++;
      start_len = 1;
      checks++;
      if (exp_launch.size() == 0) begin
        errors++;
        $display("FAIL launch_unexpected: got slot %0d addr %02h, required no launch", CurProg, CoreStartAddr);
      end else begin
        le = exp_launch.pop_front();
        if ({CurProg, CoreStartAddr} !== {le.slot, le.addr}) begin
          errors++;
          $display("FAIL launch_order: got slot %0d addr %02h, required slot %0d addr %02h",
                   CurProg, CoreStartAddr, le.slot, le.addr);
        end
      end
    end else if (CoreStart === 1'b1) begin
      start_len++;
    end else if (prev_start) begin
      checks++;
      if (start_len != 2) begin
        errors++;
        $display("FAIL start_len: got %0d cycles, required 2", start_len);
      end
    end
    prev_start = (CoreStart === 1'b1);
    if (CountValid === 1'b1) begin
      cv_count++;
      checks++;
      if (exp_count.size() == 0) begin
        errors++;
        $display("FAIL count_unexpected: got slot %0d count %0d, required none", CurProg, CycleCount);
      end else begin
        ce = exp_count.pop_front();
        if ({CurProg, CycleCount} !== {ce.slot, ce.cnt}) begin
          errors++;
          $display("FAIL cycle_count: got slot %0d count %0d, required slot %0d count %0d",
                   CurProg, CycleCount, ce.slot, ce.cnt);
        end
      end
    end
    if (RunAck === 1'b1) ack_count++;
  end

  task automatic push_exp(input logic [2:0] slot, input logic [7:0] addr, input logic [15:0] cnt);
    exp_launch.push_back('{slot: slot, addr: addr});
    exp_count.push_back('{slot: slot, cnt: cnt});
  endtask

  task automatic start_run();
    @(negedge CLK); RunReq = 1'b1;
    @(negedge CLK); RunReq = 1'b0;
  endtask

  task automatic wait_ack(input int budget, output bit got);
    got = 1'b0;
    for (int c = 0; c < budget && !got; c++) begin
      @(negedge CLK);
      if (RunAck === 1'b1) got = 1'b1;
    end
  endtask

  task automatic test_reset();
    @(negedge CLK);
    checks++;
    if ({CoreStart, Busy, RunAck, CountValid, TimedOut} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b, required 00000", {CoreStart, Busy, RunAck, CountValid, TimedOut});
    end
    checks++;
    if ({CurProg, CoreStartAddr, CycleCount} !== 27'd0) begin
      errors++;
      $display("FAIL reset_data: got prog %0d addr %02h count %0d, required all 0", CurProg, CoreStartAddr, CycleCount);
    end
  endtask

  task automatic test_basic();
    bit got; int a0;
    core_mode = 0; done_delay = 10; ProgMask = 3'b111; a0 = ack_count;
    push_exp(3'd0, 8'h00, 16'd10); push_exp(3'd1, 8'h40, 16'd10); push_exp(3'd2, 8'h80, 16'd10);
    start_run();
    wait_ack(300, got);
    checks++;
    if (!got) begin errors++; $display("FAIL basic_ack: got no RunAck, required one"); end
    checks++;
    if (TimedOut !== 1'b0) begin errors++; $display("FAIL basic_timedout: got %b, required 0", TimedOut); end
    repeat (4) @(negedge CLK);
    checks++;
    if (exp_launch.size() != 0 || exp_count.size() != 0) begin
      errors++;
      $display("FAIL basic_drain: got %0d launches %0d counts pending, required 0", exp_launch.size(), exp_count.size());
    end
    checks++;
    if (ack_count != a0 + 1 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_ack_once: got %0d acks busy %b, required 1 ack busy 0", ack_count - a0, Busy);
    end
`ifdef SEQ_PERF_LOG_EN
    LogIdx = 3'd1; #1;
    checks++;
    if (LogData !== 16'd10) begin errors++; $display("FAIL perf_log: got %0d, required 10", LogData); end
`endif
  endtask

  task automatic test_skip();
    bit got; int c0;
    core_mode = 0; done_delay = 10; ProgMask = 3'b101; c0 = cv_count;
    push_exp(3'd0, 8'h00, 16'd10); push_exp(3'd2, 8'h80, 16'd10);
    start_run();
    ProgMask = 3'b111;   // must not affect the run already accepted
    wait_ack(300, got);
    repeat (2) @(negedge CLK);
    checks++;
    if (!got || exp_launch.size() != 0 || exp_count.size() != 0 || cv_count != c0 + 2) begin
      errors++;
      $display("FAIL skip: got ack %b pending %0d valids %0d, required ack 1 pending 0 valids 2",
               got, exp_launch.size() + exp_count.size(), cv_count - c0);
    end
  endtask

  task automatic test_stale_done();
    bit got;
    core_mode = 1; ProgMask = 3'b011;
    push_exp(3'd0, 8'h00, 16'd2); push_exp(3'd1, 8'h40, 16'd2);
    start_run();
    wait_ack(300, got);
    repeat (2) @(negedge CLK);
    checks++;
    if (!got || exp_count.size() != 0 || TimedOut !== 1'b0) begin
      errors++;
      $display("FAIL stale_done: got ack %b pending %0d timedout %b, required 1 0 0", got, exp_count.size(), TimedOut);
    end
  endtask

  task automatic test_timeout();
    bit got;
    core_mode = 2; ProgMask = 3'b011;
    push_exp(3'd0, 8'h00, 16'd20); push_exp(3'd1, 8'h40, 16'd20);
    start_run();
    wait_ack(300, got);
    checks++;
    if (!got || TimedOut !== 1'b1) begin
      errors++;
      $display("FAIL timeout: got ack %b timedout %b, required 1 1", got, TimedOut);
    end
    repeat (2) @(negedge CLK);
    checks++;
    if (exp_count.size() != 0) begin errors++; $display("FAIL timeout_drain: got %0d pending, required 0", exp_count.size()); end
  endtask

  task automatic test_done_at_limit();
    bit got;
    core_mode = 0; done_delay = 20; ProgMask = 3'b001;
    push_exp(3'd0, 8'h00, 16'd20);
    start_run();
    wait_ack(300, got);
    checks++;
    if (!got || TimedOut !== 1'b0) begin
      errors++;
      $display("FAIL done_vs_timeout: got ack %b timedout %b, required 1 0", got, TimedOut);
    end
    repeat (2) @(negedge CLK);
    done_delay = 10;
  endtask

  task automatic test_reset_mid_run();
    bit got, seen;
    core_mode = 2; ProgMask = 3'b111; seen = 1'b0;
    exp_launch.push_back('{slot: 3'd0, addr: 8'h00});
    exp_launch.push_back('{slot: 3'd1, addr: 8'h40});
    exp_count.push_back('{slot: 3'd0, cnt: 16'd20});
    start_run();
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge CLK);
      if (CurProg === 3'd1 && Busy === 1'b1 && CoreStart === 1'b0) seen = 1'b1;
    end
    repeat (3) @(negedge CLK);
    checks++;
    if (!seen || TimedOut !== 1'b1) begin
      errors++;
      $display("FAIL mid_run_reach: got in-run %b timedout %b, required 1 1", seen, TimedOut);
    end
    Reset = 1'b1;
    @(negedge CLK);
    checks++;
    if ({CoreStart, Busy, TimedOut, CurProg} !== 6'b0) begin
      errors++;
      $display("FAIL mid_run_reset: got start %b busy %b timedout %b prog %0d, required all 0",
               CoreStart, Busy, TimedOut, CurProg);
    end
    Reset = 1'b0;
    core_mode = 0;
    push_exp(3'd0, 8'h00, 16'd10); push_exp(3'd1, 8'h40, 16'd10); push_exp(3'd2, 8'h80, 16'd10);
    start_run();
    wait_ack(300, got);
    repeat (2) @(negedge CLK);
    checks++;
    if (!got || exp_launch.size() != 0 || exp_count.size() != 0) begin
      errors++;
      $display("FAIL restart: got ack %b pending %0d, required 1 0", got, exp_launch.size() + exp_count.size());
    end
  endtask

  task automatic test_empty_mask();
    int a0, l0;
    ProgMask = 3'b000; a0 = ack_count; l0 = launch_count;
    @(negedge CLK); RunReq = 1'b1;
    @(negedge CLK); RunReq = 1'b0;
    checks++;
    if (Busy !== 1'b1) begin errors++; $display("FAIL empty_busy: got %b, required 1", Busy); end
    @(negedge CLK); RunReq = 1'b1;   // second request while busy
    checks++;
    if (RunAck !== 1'b0) begin errors++; $display("FAIL empty_ack_early: got %b, required 0", RunAck); end
    @(negedge CLK);
    checks++;
    if ({RunAck, Busy} !== 2'b11) begin errors++; $display("FAIL empty_ack: got ack,busy %b, required 11", {RunAck, Busy}); end
    @(negedge CLK); RunReq = 1'b0;
    checks++;
    if ({RunAck, Busy} !== 2'b00) begin errors++; $display("FAIL empty_release: got ack,busy %b, required 00", {RunAck, Busy}); end
    repeat (10) @(negedge CLK);
    checks++;
    if (ack_count != a0 + 1 || launch_count != l0 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL empty_ignored: got %0d acks %0d launches busy %b, required 1 0 0",
               ack_count - a0, launch_count - l0, Busy);
    end
  endtask

  initial begin
    Reset = 1'b1; RunReq = 1'b0; ProgMask = '0;
    ProgAddrs = {8'h80, 8'h40, 8'h00};
`ifdef SEQ_PERF_LOG_EN
    LogIdx = 3'd0;
`endif
    repeat (3) @(negedge CLK);
    Reset = 1'b0;
    test_reset();
    test_basic();
    test_skip();
    test_stale_done();
    test_timeout();
    test_done_at_limit();
    test_reset_mid_run();
    test_empty_mask();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
